// File: rtl/sig_pulse_width_mon_if.sv
// Bus bundle for sig_pulse_width_mon: control/monitored inputs and measurement/status outputs.
interface sig_pulse_width_mon_if #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             sig;
  logic             pulse_done;
  logic [LEN_W-1:0] pulse_len;
  logic             short_err;
  logic             long_err;
  logic             err_sticky;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output en, clr, sig,
    input  pulse_done, pulse_len, short_err, long_err, err_sticky, ok_cnt, err_cnt
  );

  modport slave (
    input  en, clr, sig,
    output pulse_done, pulse_len, short_err, long_err, err_sticky, ok_cnt, err_cnt
  );
endinterface

// File: rtl/sig_pulse_width_mon.sv
// High-run width monitor: measures each high run of sig, flags runs outside MIN_W..MAX_W.
// Optional embedded assertions are compiled when PW_MON_SVA_EN is defined.
module sig_pulse_width_mon #(
  parameter int MIN_W = 2,
  parameter int MAX_W = 6,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sig_pulse_width_mon_if.slave bus
);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, OVER} state_t;

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_W);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_W);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic             pulse_done_r;
  logic [LEN_W-1:0] pulse_len_r;
  logic             short_err_r;
  logic             long_err_r;
  logic             err_sticky_r;
  logic [CNT_W-1:0] ok_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic             ok_inc;
  logic             err_inc;

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Decisions taken at this edge; a run reaching MAX_W+1 samples is counted once, on entry to OVER.
  always_comb begin
    ok_inc  = 1'b0;
    err_inc = 1'b0;
    if (bus.en && state == HIGH) begin
      if (bus.sig) begin
        err_inc = (len == MAX_L);
      end else if (len < MIN_L) begin
        err_inc = 1'b1;
      end else begin
        ok_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SYNC;
      len          <= '0;
      pulse_done_r <= 1'b0;
      pulse_len_r  <= '0;
      short_err_r  <= 1'b0;
      long_err_r   <= 1'b0;
    end else begin
      pulse_done_r <= 1'b0;
      short_err_r  <= 1'b0;
      long_err_r   <= 1'b0;
      if (!bus.en) begin
        state <= SYNC;
        len   <= '0;
      end else begin
        case (state)
          SYNC: if (!bus.sig) state <= IDLE;
          IDLE: if (bus.sig) begin
            state <= HIGH;
            len   <= LEN_W'(1);
          end
          HIGH: if (bus.sig) begin
            len <= len + 1'b1;
            if (len == MAX_L) begin
              long_err_r <= 1'b1;
              state      <= OVER;
            end
          end else begin
            pulse_done_r <= 1'b1;
            pulse_len_r  <= len;
            short_err_r  <= (len < MIN_L);
            state        <= IDLE;
          end
          OVER: if (bus.sig) begin
            len <= sat_len(len);
          end else begin
            pulse_done_r <= 1'b1;
            pulse_len_r  <= len;
            state        <= IDLE;
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  // Status counters; clr takes priority over any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_r     <= '0;
      err_cnt_r    <= '0;
      err_sticky_r <= 1'b0;
    end else if (bus.clr) begin
      ok_cnt_r     <= '0;
      err_cnt_r    <= '0;
      err_sticky_r <= 1'b0;
    end else begin
      if (ok_inc)  ok_cnt_r  <= sat_cnt(ok_cnt_r);
      if (err_inc) begin
        err_cnt_r    <= sat_cnt(err_cnt_r);
        err_sticky_r <= 1'b1;
      end
    end
  end

  assign bus.pulse_done = pulse_done_r;
  assign bus.pulse_len  = pulse_len_r;
  assign bus.short_err  = short_err_r;
  assign bus.long_err   = long_err_r;
  assign bus.err_sticky = err_sticky_r;
  assign bus.ok_cnt     = ok_cnt_r;
  assign bus.err_cnt    = err_cnt_r;

`ifdef PW_MON_SVA_EN
  a_duration: assert property (@(posedge clk) disable iff (!rst_n || !bus.en)
    !(bus.short_err || bus.long_err))
    else $error("illegal high run on sig (short=%0b long=%0b)", bus.short_err, bus.long_err);

  a_short_done: assert property (@(posedge clk) disable iff (!rst_n || !bus.en)
    bus.short_err |-> bus.pulse_done);

  a_long_alone: assert property (@(posedge clk) disable iff (!rst_n || !bus.en)
    bus.long_err |-> (!bus.pulse_done && !bus.short_err));

  a_err_mono: assert property (@(posedge clk) disable iff (!rst_n || !bus.en)
    !bus.clr |=> (bus.err_cnt >= $past(bus.err_cnt)));
`else
`endif

endmodule
